// File: rtl/cpu_btb_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : CPU_Types (package)
// Description : Shared types and constants for the BTB update controller.
//               btb_update_t is the packed {tag, index, target} record held
//               in the pending-update queue (default 64-entry geometry).
//               Controller states are encoded as explicit 2-bit localparams.
// Revision    : 1.0 - initial release
// ============================================================================
package CPU_Types;

    localparam int BTB_ENTRIES         = 64;
    localparam int BTB_UPD_QUEUE_DEPTH = 4;
    localparam int BTB_INDEX_BITS      = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_BITS        = 30 - BTB_INDEX_BITS;

    typedef struct packed {
        logic [BTB_TAG_BITS-1:0]   tag;
        logic [BTB_INDEX_BITS-1:0] index;
        logic [31:0]               target;
    } btb_update_t;

    typedef logic [1:0] btb_upd_state_t;

    localparam btb_upd_state_t c_st_idle  = 2'd0;
    localparam btb_upd_state_t c_st_drain = 2'd1;
    localparam btb_upd_state_t c_st_sweep = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cpu_btb_update_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cpu_btb_update_fifo
// Description : Synchronous FIFO for pending BTB updates. Pointers carry one
//               extra wrap bit so full/empty fall out of an MSB compare.
//               Besides push/pop and a head peek it exposes every slot's
//               contents plus an occupancy mask and a per-slot write port,
//               which lets the controller merge updates in place.
// Ports       : i_clk/i_rst_n (async active-low), i_flush, i_push/i_push_data,
//               i_pop, o_head_data/o_head_slot, o_full, o_empty,
//               i_slot_wr_en/i_slot_wr_idx/i_slot_wr_data,
//               o_slot_data (flattened, slot s at [s*WIDTH +: WIDTH]),
//               o_slot_live (bit s set when slot s holds a queued entry)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_btb_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 62,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_data,
    output logic [AW-1:0]          o_head_slot,
    output logic                   o_full,
    output logic                   o_empty,
    input  logic                   i_slot_wr_en,
    input  logic [AW-1:0]          i_slot_wr_idx,
    input  logic [WIDTH-1:0]       i_slot_wr_data,
    output logic [DEPTH*WIDTH-1:0] o_slot_data,
    output logic [DEPTH-1:0]       o_slot_live
);

    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        if (i_slot_wr_en)       r_mem[i_slot_wr_idx]    <= i_slot_wr_data;
    end

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head_slot = r_rd_ptr[AW-1:0];
    assign o_head_data = r_mem[r_rd_ptr[AW-1:0]];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        // A slot is occupied when its distance from the head is below the count.
        logic [AW-1:0] w_off;
        assign w_off = AW'(gi) - r_rd_ptr[AW-1:0];
        assign o_slot_live[gi] = ({1'b0, w_off} < w_count);
        assign o_slot_data[gi*WIDTH +: WIDTH] = r_mem[gi];
    end

endmodule
`default_nettype wire

// File: rtl/cpu_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_btb_update_ctrl
// Description : Sequences all writes into a direct-mapped BTB with a single
//               write port. Mispredict updates are queued and drained; a full
//               invalidate sweep runs after reset and on every fence.i pulse.
//               Write-port outputs are registered; o_update_ready and o_busy
//               are decoded from registered state (ready also honours the
//               same-cycle invalidate so colliding updates are dropped).
// Ports       : i_clock, i_reset_n (async active-low)
//               update in : i_update_valid/o_update_ready, i_update_pc,
//                           i_update_target
//               control   : i_invalidate (fence.i pulse), o_busy
//               BTB write : o_wr_en/i_wr_ready, o_wr_index, o_wr_tag,
//                           o_wr_target, o_wr_valid
// Options     : CPU_BTB_UPD_COALESCE_EN - merge an update into a queued entry
//               with the same index instead of pushing a new one.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_btb_update_ctrl
    import CPU_Types::*;
#(
    parameter int ENTRIES     = BTB_ENTRIES,
    parameter int QUEUE_DEPTH = BTB_UPD_QUEUE_DEPTH,
    parameter int INDEX_BITS  = $clog2(ENTRIES),
    parameter int TAG_BITS    = 30 - INDEX_BITS
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_update_valid,
    output logic                  o_update_ready,
    input  logic [31:0]           i_update_pc,
    input  logic [31:0]           i_update_target,
    input  logic                  i_invalidate,
    output logic                  o_busy,
    output logic                  o_wr_en,
    input  logic                  i_wr_ready,
    output logic [INDEX_BITS-1:0] o_wr_index,
    output logic [TAG_BITS-1:0]   o_wr_tag,
    output logic [31:0]           o_wr_target,
    output logic                  o_wr_valid
);

    localparam int UPD_W = TAG_BITS + INDEX_BITS + 32;
    localparam int QAW   = $clog2(QUEUE_DEPTH);
    localparam logic [INDEX_BITS-1:0] c_last_idx = INDEX_BITS'(ENTRIES - 1);

    // ---------------- registered state ----------------
    btb_upd_state_t        r_state;
    logic [INDEX_BITS-1:0] r_sweep_idx;
    logic                  r_wr_en;
    logic [INDEX_BITS-1:0] r_wr_index;
    logic [TAG_BITS-1:0]   r_wr_tag;
    logic [31:0]           r_wr_target;
    logic                  r_wr_valid;

    btb_upd_state_t        w_state_nxt;
    logic [INDEX_BITS-1:0] w_sweep_idx_nxt;
    logic                  w_wr_en_nxt;
    logic [INDEX_BITS-1:0] w_wr_index_nxt;
    logic [TAG_BITS-1:0]   w_wr_tag_nxt;
    logic [31:0]           w_wr_target_nxt;
    logic                  w_wr_valid_nxt;

    // ---------------- queue interface ----------------
    logic [UPD_W-1:0]             w_upd_data;
    logic [INDEX_BITS-1:0]        w_upd_index;
    logic [TAG_BITS-1:0]          w_upd_tag;
    logic [UPD_W-1:0]             w_head_data;
    logic [QAW-1:0]               w_head_slot;
    logic                         w_full;
    logic                         w_empty;
    logic [QUEUE_DEPTH*UPD_W-1:0] w_slot_data;
    logic [QUEUE_DEPTH-1:0]       w_slot_live;
    logic                         w_hit;
    logic [QAW-1:0]               w_hit_slot;

    logic w_hs;
    logic w_can_load;
    logic w_pop;
    logic w_ready;
    logic w_accept;
    logic w_bypass;
    logic w_push;
    logic w_slot_wr;
    logic w_unused_pc;

    assign w_upd_index = i_update_pc[2 +: INDEX_BITS];
    assign w_upd_tag   = i_update_pc[31 -: TAG_BITS];
    assign w_upd_data  = {w_upd_tag, w_upd_index, i_update_target};
    assign w_unused_pc = ^i_update_pc[1:0];

    assign w_hs       = r_wr_en && i_wr_ready;
    // The write port can take a new entry when idle or when the current one completes.
    assign w_can_load = (r_state == c_st_idle) || ((r_state == c_st_drain) && w_hs);
    assign w_pop      = w_can_load && !w_empty && !i_invalidate;

`ifdef CPU_BTB_UPD_COALESCE_EN
    // Lowest queued slot with the same index; the head being popped this edge
    // moves onto the write port and is therefore excluded.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_slot = '0;
        for (int s = 0; s < QUEUE_DEPTH; s++) begin
            if (!w_hit && w_slot_live[s] &&
                (w_slot_data[s*UPD_W + 32 +: INDEX_BITS] == w_upd_index) &&
                !(w_pop && (QAW'(s) == w_head_slot))) begin
                w_hit      = 1'b1;
                w_hit_slot = QAW'(s);
            end
        end
    end
`else
    logic w_unused_slots;
    assign w_hit          = 1'b0;
    assign w_hit_slot     = '0;
    assign w_unused_slots = ^{w_slot_data, w_slot_live, w_head_slot};
`endif

    // Occupancy is taken before any same-edge pop, so a full queue refuses.
    assign w_ready   = (!w_full || w_hit) && (r_state != c_st_sweep) && !i_invalidate;
    assign w_accept  = i_update_valid && w_ready;
    // With nothing queued, an accepted update goes straight onto the write port.
    assign w_bypass  = w_can_load && w_empty && w_accept;
    assign w_push    = w_accept && !w_bypass && !w_hit;
    assign w_slot_wr = w_accept && !w_bypass && w_hit;

    cpu_btb_update_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (UPD_W)
    ) u_fifo (
        .i_clk          (i_clock),
        .i_rst_n        (i_reset_n),
        .i_flush        (i_invalidate),
        .i_push         (w_push),
        .i_push_data    (w_upd_data),
        .i_pop          (w_pop),
        .o_head_data    (w_head_data),
        .o_head_slot    (w_head_slot),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .i_slot_wr_en   (w_slot_wr),
        .i_slot_wr_idx  (w_hit_slot),
        .i_slot_wr_data (w_upd_data),
        .o_slot_data    (w_slot_data),
        .o_slot_live    (w_slot_live)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        w_wr_en_nxt     = r_wr_en;
        w_wr_index_nxt  = r_wr_index;
        w_wr_tag_nxt    = r_wr_tag;
        w_wr_target_nxt = r_wr_target;
        w_wr_valid_nxt  = r_wr_valid;

        case (r_state)
            c_st_sweep: begin
                w_wr_en_nxt     = 1'b1;
                w_wr_valid_nxt  = 1'b0;
                w_wr_tag_nxt    = '0;
                w_wr_target_nxt = '0;
                w_wr_index_nxt  = r_sweep_idx;
                if (w_hs) begin
                    if (r_sweep_idx == c_last_idx) begin
                        w_state_nxt     = c_st_idle;
                        w_wr_en_nxt     = 1'b0;
                        w_sweep_idx_nxt = '0;
                        w_wr_index_nxt  = '0;
                    end else begin
                        w_sweep_idx_nxt = r_sweep_idx + INDEX_BITS'(1);
                        w_wr_index_nxt  = r_sweep_idx + INDEX_BITS'(1);
                    end
                end
            end
            c_st_idle, c_st_drain: begin
                if (w_can_load) begin
                    if (!w_empty) begin
                        w_state_nxt     = c_st_drain;
                        w_wr_en_nxt     = 1'b1;
                        w_wr_valid_nxt  = 1'b1;
                        w_wr_tag_nxt    = w_head_data[UPD_W-1 -: TAG_BITS];
                        w_wr_index_nxt  = w_head_data[32 +: INDEX_BITS];
                        w_wr_target_nxt = w_head_data[31:0];
                    end else if (w_accept) begin
                        w_state_nxt     = c_st_drain;
                        w_wr_en_nxt     = 1'b1;
                        w_wr_valid_nxt  = 1'b1;
                        w_wr_tag_nxt    = w_upd_tag;
                        w_wr_index_nxt  = w_upd_index;
                        w_wr_target_nxt = i_update_target;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_wr_en_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt     = c_st_sweep;
                w_sweep_idx_nxt = '0;
                w_wr_en_nxt     = 1'b0;
            end
        endcase

        // fence.i overrides everything, abandoning any write in flight.
        if (i_invalidate) begin
            w_state_nxt     = c_st_sweep;
            w_sweep_idx_nxt = '0;
            w_wr_en_nxt     = 1'b1;
            w_wr_valid_nxt  = 1'b0;
            w_wr_index_nxt  = '0;
            w_wr_tag_nxt    = '0;
            w_wr_target_nxt = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= c_st_sweep;
            r_sweep_idx <= '0;
            r_wr_en     <= 1'b0;
            r_wr_index  <= '0;
            r_wr_tag    <= '0;
            r_wr_target <= '0;
            r_wr_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_idx_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_index  <= w_wr_index_nxt;
            r_wr_tag    <= w_wr_tag_nxt;
            r_wr_target <= w_wr_target_nxt;
            r_wr_valid  <= w_wr_valid_nxt;
        end
    end

    assign o_update_ready = w_ready;
    assign o_busy         = (r_state != c_st_idle) || !w_empty;
    assign o_wr_en        = r_wr_en;
    assign o_wr_index     = r_wr_index;
    assign o_wr_tag       = r_wr_tag;
    assign o_wr_target    = r_wr_target;
    assign o_wr_valid     = r_wr_valid;

endmodule
`default_nettype wire
